// File: rtl/hs_clk_lane_fsm.sv
// D-PHY HS clock-lane controller with an integrated interval timer.
// It sequences LP-11 -> HS clock -> LP-11 and drives the LP levels and the HS enables.
module hs_clk_lane_fsm #(
   parameter int CNT_W     = 6,
   parameter int T_LPX     = 5,
   parameter int T_PREPARE = 4,
   parameter int T_ZERO    = 27,
   parameter int T_PRE     = 2,
   parameter int T_POST    = 6,
   parameter int T_TRAIL   = 6,
   parameter int T_HS_EXIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_enable,
   input  logic       hs_req,
   input  logic       cont_mode,
   input  logic       data_idle,
   output logic       lp_dp,
   output logic       lp_dn,
   output logic       hs_tx_en,
   output logic       hs_clk_gate,
   output logic       clk_ready,
   output logic       busy,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LPX     = 4'd1,
      S_PREPARE = 4'd2,
      S_ZERO    = 4'd3,
      S_PRE     = 4'd4,
      S_ACTIVE  = 4'd5,
      S_POST    = 4'd6,
      S_TRAIL   = 4'd7,
      S_EXIT    = 4'd8
   } state_t;

   // Counter load values: a state loaded with T-1 is occupied exactly T cycles.
   localparam logic [CNT_W-1:0] LD_LPX     = CNT_W'(T_LPX - 1);
   localparam logic [CNT_W-1:0] LD_PREPARE = CNT_W'(T_PREPARE - 1);
   localparam logic [CNT_W-1:0] LD_ZERO    = CNT_W'(T_ZERO - 1);
   localparam logic [CNT_W-1:0] LD_PRE     = CNT_W'(T_PRE - 1);
   localparam logic [CNT_W-1:0] LD_POST    = CNT_W'(T_POST - 1);
   localparam logic [CNT_W-1:0] LD_TRAIL   = CNT_W'(T_TRAIL - 1);
   localparam logic [CNT_W-1:0] LD_EXIT    = CNT_W'(T_HS_EXIT - 1);

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt_cnt;
   logic             cont_latched;
   logic             cnt_done;
   logic             stop_req;

   // {lp_dp, lp_dn, hs_tx_en, hs_clk_gate, clk_ready, busy}
   function automatic logic [5:0] decode(input state_t s);
      case (s)
         S_IDLE:    decode = 6'b110000;
         S_LPX:     decode = 6'b010001;
         S_PREPARE: decode = 6'b000001;
         S_ZERO:    decode = 6'b001001;
         S_PRE:     decode = 6'b001101;
         S_ACTIVE:  decode = 6'b001111;
         S_POST:    decode = 6'b001101;
         S_TRAIL:   decode = 6'b001001;
         S_EXIT:    decode = 6'b110001;
         default:   decode = 6'b110000;
      endcase
   endfunction

   assign cnt_done = (cnt == '0);
   // hs_enable low overrides continuous mode; data_idle gating is applied in ACTIVE.
   assign stop_req = !hs_enable || (!hs_req && !cont_latched);

   always_comb begin
      nxt     = state;
      nxt_cnt = cnt - CNT_W'(1);
      case (state)
         S_IDLE: begin
            nxt_cnt = '0;
            if (hs_enable && hs_req) begin
               nxt     = S_LPX;
               nxt_cnt = LD_LPX;
            end
         end
         S_LPX:     if (cnt_done) begin nxt = S_PREPARE; nxt_cnt = LD_PREPARE; end
         S_PREPARE: if (cnt_done) begin nxt = S_ZERO;    nxt_cnt = LD_ZERO;    end
         S_ZERO:    if (cnt_done) begin nxt = S_PRE;     nxt_cnt = LD_PRE;     end
         S_PRE:     if (cnt_done) begin nxt = S_ACTIVE;  nxt_cnt = '0;         end
         S_ACTIVE: begin
            nxt_cnt = '0;
            if (data_idle && stop_req) begin
               nxt     = S_POST;
               nxt_cnt = LD_POST;
            end
         end
         S_POST:    if (cnt_done) begin nxt = S_TRAIL;   nxt_cnt = LD_TRAIL;   end
         S_TRAIL:   if (cnt_done) begin nxt = S_EXIT;    nxt_cnt = LD_EXIT;    end
         S_EXIT:    if (cnt_done) begin nxt = S_IDLE;    nxt_cnt = '0;         end
         default: begin
            nxt     = S_IDLE;
            nxt_cnt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         cont_latched <= 1'b0;
         {lp_dp, lp_dn, hs_tx_en, hs_clk_gate, clk_ready, busy} <= 6'b110000;
      end else begin
         state <= nxt;
         cnt   <= nxt_cnt;
         if (state == S_IDLE && nxt == S_LPX)
            cont_latched <= cont_mode;
         {lp_dp, lp_dn, hs_tx_en, hs_clk_gate, clk_ready, busy} <= decode(nxt);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_hs_clk_lane_fsm.sv
// Bench for hs_clk_lane_fsm: expected state trace queued per scenario, compared cycle by cycle.
// A second instance with all intervals at 1 covers the minimum-timing corner.
module tb_hs_clk_lane_fsm;

   localparam logic [3:0] IDLE = 4'd0, LPX = 4'd1, PREP = 4'd2, ZERO = 4'd3, PRE = 4'd4,
                          ACT = 4'd5, POST = 4'd6, TRAIL = 4'd7, EXIT = 4'd8;

   logic       clk = 1'b0;
   logic       rst;
   logic       hs_enable, hs_req, cont_mode, data_idle;
   logic       lp_dp, lp_dn, hs_tx_en, hs_clk_gate, clk_ready, busy;
   logic [3:0] state_o;
   logic       m_enable, m_req, m_cont, m_idle;
   logic       m_dp, m_dn, m_tx, m_gate, m_ready, m_busy;
   logic [3:0] m_state;
   logic [5:0] obs, m_obs;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] e;

   always #5 clk = ~clk;

   assign obs   = {lp_dp, lp_dn, hs_tx_en, hs_clk_gate, clk_ready, busy};
   assign m_obs = {m_dp, m_dn, m_tx, m_gate, m_ready, m_busy};

   hs_clk_lane_fsm dut (
      .clk(clk), .rst(rst), .hs_enable(hs_enable), .hs_req(hs_req),
      .cont_mode(cont_mode), .data_idle(data_idle), .lp_dp(lp_dp), .lp_dn(lp_dn),
      .hs_tx_en(hs_tx_en), .hs_clk_gate(hs_clk_gate), .clk_ready(clk_ready),
      .busy(busy), .state_o(state_o)
   );

   hs_clk_lane_fsm #(
      .CNT_W(3), .T_LPX(1), .T_PREPARE(1), .T_ZERO(1), .T_PRE(1),
      .T_POST(1), .T_TRAIL(1), .T_HS_EXIT(1)
   ) dut_min (
      .clk(clk), .rst(rst), .hs_enable(m_enable), .hs_req(m_req),
      .cont_mode(m_cont), .data_idle(m_idle), .lp_dp(m_dp), .lp_dn(m_dn),
      .hs_tx_en(m_tx), .hs_clk_gate(m_gate), .clk_ready(m_ready),
      .busy(m_busy), .state_o(m_state)
   );

   // Output table {lp_dp, lp_dn, hs_tx_en, hs_clk_gate, clk_ready, busy} per state.
   function automatic logic [5:0] exp_outs(input logic [3:0] s);
      case (s)
         IDLE:    return 6'b110000;
         LPX:     return 6'b010001;
         PREP:    return 6'b000001;
         ZERO:    return 6'b001001;
         PRE:     return 6'b001101;
         ACT:     return 6'b001111;
         POST:    return 6'b001101;
         TRAIL:   return 6'b001001;
         EXIT:    return 6'b110001;
         default: return 6'bxxxxxx;
      endcase
   endfunction

   task automatic push_n(input logic [3:0] s, input int n);
      repeat (n) exp_q.push_back(s);
   endtask

   task automatic push_startup(input int active_cycles);
      push_n(LPX, 5); push_n(PREP, 4); push_n(ZERO, 27); push_n(PRE, 2);
      push_n(ACT, active_cycles);
   endtask

   task automatic push_shutdown();
      push_n(POST, 6); push_n(TRAIL, 6); push_n(EXIT, 10); push_n(IDLE, 2);
   endtask

   task automatic test_reset();
      rst = 1'b0; hs_enable = 1'b1; hs_req = 1'b1; cont_mode = 1'b0; data_idle = 1'b1;
      m_enable = 1'b1; m_req = 1'b0; m_cont = 1'b0; m_idle = 1'b1;
      #1;
      push_n(IDLE, 10);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL reset_hold: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (state_o !== IDLE || obs !== 6'b110000) begin
         errors++;
         $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=110000", state_o, obs);
      end
      push_n(LPX, 1);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL reset_first_req: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      // Return to IDLE for the following scenarios.
      rst = 1'b0; hs_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_cycle();
      int lpx_edge, ready_edge, cyc;
      hs_enable = 1'b1; hs_req = 1'b1; data_idle = 1'b1; cont_mode = 1'b0;
      push_startup(3);
      cyc = 0; lpx_edge = -1; ready_edge = -1;
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         cyc++;
         if (lpx_edge < 0 && state_o == LPX) lpx_edge = cyc;
         if (ready_edge < 0 && clk_ready === 1'b1) ready_edge = cyc;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL full_startup: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      checks++;
      if (ready_edge - lpx_edge !== 38) begin
         errors++;
         $display("FAIL full_latency: clk_ready after %0d cycles, expected 38", ready_edge - lpx_edge);
      end
      hs_req = 1'b0;
      push_shutdown();
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL full_shutdown: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
   endtask

   task automatic test_interlock();
      hs_enable = 1'b1; hs_req = 1'b1; data_idle = 1'b0; cont_mode = 1'b0;
      push_startup(2);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL interlock_startup: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      hs_req = 1'b0;
      push_n(ACT, 15);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL interlock_hold: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      data_idle = 1'b1;
      push_shutdown();
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL interlock_release: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
   endtask

   task automatic test_continuous();
      hs_enable = 1'b1; hs_req = 1'b1; data_idle = 1'b1; cont_mode = 1'b1;
      push_startup(2);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL cont_startup: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      // cont_mode was latched at LPX entry, so dropping it now must not matter.
      hs_req = 1'b0; cont_mode = 1'b0;
      push_n(ACT, 10);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL cont_hold: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      hs_enable = 1'b0;
      push_shutdown();
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL cont_stop: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      hs_enable = 1'b1;
   endtask

   task automatic test_abort();
      hs_enable = 1'b1; hs_req = 1'b1; data_idle = 1'b1; cont_mode = 1'b0;
      push_n(LPX, 5); push_n(PREP, 4); push_n(ZERO, 10);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL abort_zero: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      hs_req = 1'b0;
      push_n(ZERO, 17); push_n(PRE, 2); push_n(ACT, 1); push_shutdown();
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL abort_complete: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      hs_req = 1'b1;
      push_n(LPX, 5); push_n(PREP, 4); push_n(ZERO, 27); push_n(PRE, 1);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL abort_to_pre: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (state_o !== IDLE || obs !== 6'b110000) begin
         errors++;
         $display("FAIL abort_async_reset: state=%0d outs=%b, expected state=0 outs=110000", state_o, obs);
      end
      hs_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      push_n(IDLE, 2);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (state_o !== e || obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL abort_after_reset: state=%0d outs=%b, expected state=%0d outs=%b", state_o, obs, e, exp_outs(e));
         end
      end
   endtask

   task automatic test_back_to_back();
      m_enable = 1'b1; m_req = 1'b1; m_cont = 1'b0; m_idle = 1'b1;
      push_n(LPX, 1); push_n(PREP, 1); push_n(ZERO, 1); push_n(PRE, 1); push_n(ACT, 1);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (m_state !== e || m_obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL min_startup: state=%0d outs=%b, expected state=%0d outs=%b", m_state, m_obs, e, exp_outs(e));
         end
      end
      m_req = 1'b0;
      push_n(POST, 1); push_n(TRAIL, 1); push_n(EXIT, 1);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (m_state !== e || m_obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL min_shutdown: state=%0d outs=%b, expected state=%0d outs=%b", m_state, m_obs, e, exp_outs(e));
         end
      end
      m_req = 1'b1;
      push_n(IDLE, 1); push_n(LPX, 1); push_n(PREP, 1);
      while (exp_q.size() > 0) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (m_state !== e || m_obs !== exp_outs(e)) begin
            errors++;
            $display("FAIL min_rerequest: state=%0d outs=%b, expected state=%0d outs=%b", m_state, m_obs, e, exp_outs(e));
         end
      end
      m_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_cycle();
      test_interlock();
      test_continuous();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
